// File: rtl/prog_loader_pkg.sv
`default_nettype none
// =============================================================================
// prog_loader_pkg : state encoding and width constants shared by prog_loader
// Revision 1.0
// =============================================================================
package prog_loader_pkg;

   localparam int BYTE_W = 8;
   localparam int LEN_W  = 9;

   // Index of the 256th byte; accepting it ends a load regardless of in_last.
   localparam logic [LEN_W-1:0] LAST_IDX = 9'd255;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      VERIFY = 3'd2,
      RUN    = 3'd3,
      ERROR  = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/prog_bus_mux.sv
`default_nettype none
// =============================================================================
// prog_bus_mux : RAM-port mux, core when sel_core else loader; cpu_din always RAM
// Revision 1.0
// =============================================================================
module prog_bus_mux
   import prog_loader_pkg::*;
(
   input  logic              sel_core,
   input  logic              ld_write,
   input  logic              ld_read,
   input  logic [BYTE_W-1:0] ld_address,
   input  logic [BYTE_W-1:0] ld_dout,
   input  logic              cpu_write,
   input  logic              cpu_read,
   input  logic [BYTE_W-1:0] cpu_address,
   input  logic [BYTE_W-1:0] cpu_dout,
   output logic [BYTE_W-1:0] cpu_din,
   output logic              mem_write,
   output logic              mem_read,
   output logic [BYTE_W-1:0] mem_address,
   output logic [BYTE_W-1:0] mem_dout,
   input  logic [BYTE_W-1:0] mem_din
);

   always_comb begin
      mem_write   = ld_write;
      mem_read    = ld_read;
      mem_address = ld_address;
      mem_dout    = ld_dout;
      if (sel_core) begin
         mem_write   = cpu_write;
         mem_read    = cpu_read;
         mem_address = cpu_address;
         mem_dout    = cpu_dout;
      end
   end

   assign cpu_din = mem_din;

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// =============================================================================
// prog_loader : boot/run controller, streams a program into RAM then runs the core
// Revision 1.0 -- build macro PROG_LOADER_VERIFY_EN adds readback verify + ERROR
// =============================================================================
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter logic [BYTE_W-1:0] LOAD_BASE = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_req,
   input  logic              stop,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              cpu_rst,
   input  logic              cpu_write,
   input  logic              cpu_read,
   input  logic [BYTE_W-1:0] cpu_address,
   input  logic [BYTE_W-1:0] cpu_dout,
   output logic [BYTE_W-1:0] cpu_din,
   output logic              mem_write,
   output logic              mem_read,
   output logic [BYTE_W-1:0] mem_address,
   output logic [BYTE_W-1:0] mem_dout,
   input  logic [BYTE_W-1:0] mem_din,
   output logic              running,
   output logic [LEN_W-1:0]  load_len,
   output logic [BYTE_W-1:0] load_sum,
   output logic              err
);

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  count_q, count_d;
   logic [BYTE_W-1:0] sum_q, sum_d;
   logic              ld_write, ld_read;
   logic [BYTE_W-1:0] ld_address, ld_dout;
`ifdef PROG_LOADER_VERIFY_EN
   logic [LEN_W-1:0]  vcnt_q, vcnt_d;
   logic [BYTE_W-1:0] vsum_q, vsum_d;
`endif

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      sum_d      = sum_q;
      in_ready   = 1'b0;
      ld_write   = 1'b0;
      ld_read    = 1'b0;
      ld_address = '0;
      ld_dout    = '0;
`ifdef PROG_LOADER_VERIFY_EN
      vcnt_d     = vcnt_q;
      vsum_d     = vsum_q;
`endif
      // stop outranks everything, including a byte offered in the same cycle
      if (stop) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, ERROR: begin
               if (load_req) begin
                  state_d = LOAD;
                  count_d = '0;
                  sum_d   = '0;
               end
            end
            LOAD: begin
               in_ready = 1'b1;
               if (in_valid) begin
                  // strobe in the accept cycle; the RAM captures it on this edge
                  ld_write   = 1'b1;
                  ld_address = LOAD_BASE + count_q[BYTE_W-1:0];
                  ld_dout    = in_data;
                  count_d    = count_q + 9'd1;
                  sum_d      = sum_q ^ in_data;
                  if (in_last || count_q == LAST_IDX) begin
`ifdef PROG_LOADER_VERIFY_EN
                     state_d = VERIFY;
                     vcnt_d  = '0;
                     vsum_d  = '0;
`else
                     state_d = RUN;
`endif
                  end
               end
            end
`ifdef PROG_LOADER_VERIFY_EN
            VERIFY: begin
               // read data lags its address by one cycle, so fold in mem_din late
               vcnt_d = vcnt_q + 9'd1;
               if (vcnt_q != '0) begin
                  vsum_d = vsum_q ^ mem_din;
               end
               if (vcnt_q < count_q) begin
                  ld_read    = 1'b1;
                  ld_address = LOAD_BASE + vcnt_q[BYTE_W-1:0];
               end else if ((vsum_q ^ mem_din) == sum_q) begin
                  state_d = RUN;
               end else begin
                  state_d = ERROR;
               end
            end
`endif
            RUN: begin
               state_d = RUN;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         sum_q   <= sum_d;
      end
   end

`ifdef PROG_LOADER_VERIFY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         vcnt_q <= '0;
         vsum_q <= '0;
      end else begin
         vcnt_q <= vcnt_d;
         vsum_q <= vsum_d;
      end
   end

   // ERROR is only left by a new load or stop, which is exactly err's lifetime
   assign err = (state_q == ERROR);
`else
   assign err = 1'b0;
`endif

   assign running  = (state_q == RUN);
   assign cpu_rst  = ~running;
   assign load_len = count_q;
   assign load_sum = sum_q;

   prog_bus_mux u_bus_mux (
      .sel_core    (running),
      .ld_write    (ld_write),
      .ld_read     (ld_read),
      .ld_address  (ld_address),
      .ld_dout     (ld_dout),
      .cpu_write   (cpu_write),
      .cpu_read    (cpu_read),
      .cpu_address (cpu_address),
      .cpu_dout    (cpu_dout),
      .cpu_din     (cpu_din),
      .mem_write   (mem_write),
      .mem_read    (mem_read),
      .mem_address (mem_address),
      .mem_dout    (mem_dout),
      .mem_din     (mem_din)
   );

endmodule
`default_nettype wire
